// File: rtl/hdmi_packet_scheduler.sv
// Data-island packet arbiter: buffers audio frames, packs Audio Sample packets and
// chooses ACR / audio / InfoFrame / NULL once per packet slot.
module hdmi_packet_scheduler #(
    parameter int          NUM_CHANNELS     = 2,
    parameter int          SAMPLE_WIDTH     = 16,
    parameter int          FIFO_DEPTH       = 16,
    parameter int          NUM_INFOFRAMES   = 3,
    parameter logic [63:0] INFOFRAME_TYPES  = 64'h0000_0000_0083_8284,
    parameter int          INFOFRAME_PERIOD = 1,
    parameter int          FLUSH_CYCLES     = 2048
) (
    input  logic                                 clk_pixel,
    input  logic                                 reset,
    input  logic                                 video_field_end,
    input  logic                                 packet_enable,
    input  logic [4:0]                           packet_pixel_counter,
    input  logic                                 acr_toggle,
    input  logic                                 sample_strobe,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_word,
    output logic [7:0]                           packet_type,
    output logic [191:0]                         pkt_samples,
    output logic [3:0]                           pkt_present,
    output logic                                 pkt_layout,
    output logic [7:0]                           frame_counter,
    output logic                                 overflow
);

    localparam bit         LAYOUT1    = (NUM_CHANNELS > 2);
    localparam int         FW         = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam int         CW         = AW + 1;
    localparam int         IW         = $clog2(FLUSH_CYCLES + 1);
    localparam int         SHIFT      = 24 - SAMPLE_WIDTH;
    localparam int         MAX_POP    = LAYOUT1 ? 1 : 4;
    localparam logic [3:0] L1_PRESENT = 4'((1 << (NUM_CHANNELS / 2)) - 1);

    logic [FW-1:0]             fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [IW-1:0]             idle_q, idle_d;
    logic                      overflow_q, overflow_d;
    logic                      acr_hist_q, acr_hist_d, acr_init_q, acr_init_d;
    logic [3:0]                field_q, field_d;
    logic [NUM_INFOFRAMES-1:0] due_q, due_d;
    logic [7:0]                type_q, type_d;
    logic [191:0]              samples_q, samples_d;
    logic [3:0]                present_q, present_d;
    logic [7:0]                fc_q, fc_d;
    logic [2:0]                sent_q, sent_d;

    logic          push, full, idle_sat, acr_pending, audio_ok, if_found;
    logic [2:0]    pop_n, avail_n, if_sel;
    logic [FW-1:0] frame;
    logic [8:0]    fc_sum;

    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        push       = sample_strobe && !full;
        overflow_d = overflow_q || (sample_strobe && full);
        idle_sat   = (idle_q == IW'(FLUSH_CYCLES));
        wr_ptr_d   = wr_ptr_q + AW'(push);
        if (push)
            idle_d = '0;
        else if (idle_sat)
            idle_d = idle_q;
        else
            idle_d = idle_q + 1'b1;

        // History is captured on the first cycle after reset so a stale toggle level is not an ACR request
        acr_init_d  = 1'b1;
        acr_hist_d  = acr_init_q ? acr_hist_q : acr_toggle;
        acr_pending = acr_init_q && (acr_toggle != acr_hist_q);

        field_d = field_q;
        due_d   = due_q;
        if (video_field_end) begin
            if (field_q + 4'd1 == 4'(INFOFRAME_PERIOD)) begin
                field_d = '0;
                due_d   = '1;
            end else begin
                field_d = field_q + 4'd1;
            end
        end

        if_found = 1'b0;
        if_sel   = '0;
        for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
            if (due_d[i]) begin
                if_found = 1'b1;
                if_sel   = 3'(i);
            end
        end

        if (LAYOUT1) begin
            avail_n  = 3'd1;
            audio_ok = (count_q != '0);
        end else begin
            avail_n  = (count_q >= CW'(4)) ? 3'd4 : 3'(count_q);
            audio_ok = (count_q >= CW'(4)) || ((count_q != '0) && idle_sat);
        end

        type_d    = type_q;
        samples_d = samples_q;
        present_d = present_q;
        sent_d    = sent_q;
        pop_n     = '0;
        frame     = '0;
        if (packet_enable) begin
            samples_d = '0;
            present_d = '0;
            sent_d    = '0;
            if (acr_pending) begin
                type_d     = 8'd1;
                acr_hist_d = acr_toggle;
            end else if (audio_ok) begin
                type_d = 8'd2;
                pop_n  = avail_n;
                sent_d = avail_n;
                // Frame i, channel c lands in 24-bit slot i*NUM_CHANNELS+c for both layouts
                for (int i = 0; i < MAX_POP; i++) begin
                    if (i < int'(pop_n)) begin
                        frame        = fifo_mem[rd_ptr_q + AW'(i)];
                        present_d[i] = 1'b1;
                        for (int c = 0; c < NUM_CHANNELS; c++)
                            samples_d[(i*NUM_CHANNELS + c)*24 +: 24] =
                                24'(frame[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]) << SHIFT;
                    end
                end
                if (LAYOUT1)
                    present_d = L1_PRESENT;
            end else if (if_found) begin
                type_d = INFOFRAME_TYPES[{if_sel, 3'b000} +: 8];
                for (int i = 0; i < NUM_INFOFRAMES; i++)
                    if (3'(i) == if_sel)
                        due_d[i] = 1'b0;
            end else begin
                type_d = 8'd0;
            end
        end

        count_d  = count_q + CW'(push) - CW'(pop_n);
        rd_ptr_d = rd_ptr_q + AW'(pop_n);

        fc_sum = {1'b0, fc_q} + {6'b0, sent_q};
        fc_d   = fc_q;
        if (packet_pixel_counter == 5'd31 && type_q == 8'd2)
            fc_d = (fc_sum >= 9'd192) ? 8'(fc_sum - 9'd192) : fc_sum[7:0];
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idle_q     <= '0;
            overflow_q <= 1'b0;
            acr_hist_q <= 1'b0;
            acr_init_q <= 1'b0;
            field_q    <= '0;
            due_q      <= '1;
            type_q     <= '0;
            samples_q  <= '0;
            present_q  <= '0;
            fc_q       <= '0;
            sent_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            overflow_q <= overflow_d;
            acr_hist_q <= acr_hist_d;
            acr_init_q <= acr_init_d;
            field_q    <= field_d;
            due_q      <= due_d;
            type_q     <= type_d;
            samples_q  <= samples_d;
            present_q  <= present_d;
            fc_q       <= fc_d;
            sent_q     <= sent_d;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (push)
            fifo_mem[wr_ptr_q] <= sample_word;
    end

    assign packet_type   = type_q;
    assign pkt_samples   = samples_q;
    assign pkt_present   = present_q;
    assign pkt_layout    = LAYOUT1;
    assign frame_counter = fc_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler: a 2-channel instance and an 8-channel
// (20-bit sample) instance share the stimulus; each scenario resets before use.
module tb_hdmi_packet_scheduler;

   localparam int FLUSH = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, fieldEnd, enable, acr, strobe;
   logic [4:0]   pix;
   logic [159:0] word;

   logic [7:0]   aType, bType, aFc, bFc;
   logic [191:0] aSamples, bSamples;
   logic [3:0]   aPresent, bPresent;
   logic         aLayout, bLayout, aOverflow, bOverflow;

   int checks = 0;
   int errors = 0;

   hdmi_packet_scheduler u_dut2 (
      .clk_pixel(clk), .reset(reset), .video_field_end(fieldEnd),
      .packet_enable(enable), .packet_pixel_counter(pix), .acr_toggle(acr),
      .sample_strobe(strobe), .sample_word(word[31:0]),
      .packet_type(aType), .pkt_samples(aSamples), .pkt_present(aPresent),
      .pkt_layout(aLayout), .frame_counter(aFc), .overflow(aOverflow)
   );

   hdmi_packet_scheduler #(.NUM_CHANNELS(8), .SAMPLE_WIDTH(20)) u_dut8 (
      .clk_pixel(clk), .reset(reset), .video_field_end(fieldEnd),
      .packet_enable(enable), .packet_pixel_counter(pix), .acr_toggle(acr),
      .sample_strobe(strobe), .sample_word(word),
      .packet_type(bType), .pkt_samples(bSamples), .pkt_present(bPresent),
      .pkt_layout(bLayout), .frame_counter(bFc), .overflow(bOverflow)
   );

   // Compares one observed value against its hand-derived expectation
   task automatic checkOutput(input string tag, input logic [191:0] observed, input logic [191:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one clock cycle of inputs; pulses return low just after the edge
   task automatic applyStimulus(input logic s, input logic e, input logic [4:0] p, input logic f, input logic [159:0] w);
      @(negedge clk);
      strobe = s; enable = e; pix = p; fieldEnd = f; word = w;
      @(posedge clk);
      #1;
      strobe = 1'b0; enable = 1'b0; pix = 5'd0; fieldEnd = 1'b0;
   endtask

   task automatic pushFrame(input logic [159:0] w);
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, w);
   endtask

   task automatic pulseEnable();
      applyStimulus(1'b0, 1'b1, 5'd0, 1'b0, '0);
   endtask

   task automatic endPacket();
      applyStimulus(1'b0, 1'b0, 5'd31, 1'b0, '0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // 2-channel frame k: ch0 = A000+k, ch1 = 2000+k
   function automatic logic [159:0] frame2(input int k);
      return {128'b0, 16'(16'h2000 + k), 16'(16'hA000 + k)};
   endfunction

   function automatic logic [191:0] pack2(input int first, input int n);
      logic [191:0] r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         r[i*48 +: 24]      = {16'(16'hA000 + first + i), 8'h00};
         r[i*48 + 24 +: 24] = {16'(16'h2000 + first + i), 8'h00};
      end
      return r;
   endfunction

   function automatic logic [159:0] frame8(input int k);
      logic [159:0] w;
      for (int c = 0; c < 8; c++) w[c*20 +: 20] = 20'(c*65536 + 256 + k);
      return w;
   endfunction

   function automatic logic [191:0] pack8(input int k);
      logic [191:0] r;
      for (int c = 0; c < 8; c++) r[c*24 +: 24] = {20'(c*65536 + 256 + k), 4'h0};
      return r;
   endfunction

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0; fieldEnd = 1'b0; enable = 1'b0; acr = 1'b0; strobe = 1'b0;
      pix = 5'd0; word = '0;
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_type", 192'(aType), 192'(8'h00));
      checkOutput("rst_samples", aSamples, '0);
      checkOutput("rst_present", 192'(aPresent), 192'(4'h0));
      checkOutput("rst_fc", 192'(aFc), 192'(8'd0));
      checkOutput("rst_overflow", 192'(aOverflow), 192'(1'b0));
      checkOutput("layout_2ch", 192'(aLayout), 192'(1'b0));
      checkOutput("layout_8ch", 192'(bLayout), 192'(1'b1));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Full layout-0 packet
      for (int k = 0; k < 4; k++) pushFrame(frame2(k));
      pulseEnable();
      checkOutput("full_type", 192'(aType), 192'(8'd2));
      checkOutput("full_present", 192'(aPresent), 192'(4'b1111));
      checkOutput("full_samples", aSamples, pack2(0, 4));
      endPacket();
      checkOutput("full_fc", 192'(aFc), 192'(8'd4));
      pulseEnable();
      checkOutput("full_empty_after", 192'(aType), 192'(8'h84));

      // InfoFrame rotation and field refresh
      doReset();
      pulseEnable();
      checkOutput("if_first", 192'(aType), 192'(8'h84));
      pulseEnable();
      checkOutput("if_second", 192'(aType), 192'(8'h82));
      pulseEnable();
      checkOutput("if_third", 192'(aType), 192'(8'h83));
      pulseEnable();
      checkOutput("if_null", 192'(aType), 192'(8'h00));
      checkOutput("if_null_present", 192'(aPresent), 192'(4'h0));
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, '0);
      pulseEnable();
      checkOutput("if_refresh", 192'(aType), 192'(8'h84));
      pulseEnable();
      pulseEnable();
      checkOutput("if_refresh_third", 192'(aType), 192'(8'h83));
      applyStimulus(1'b0, 1'b1, 5'd0, 1'b1, '0);
      checkOutput("if_coincident", 192'(aType), 192'(8'h84));

      // Partial packet only after the flush timeout
      doReset();
      pushFrame(frame2(0));
      pushFrame(frame2(1));
      pulseEnable();
      checkOutput("flush_early", 192'(aType), 192'(8'h84));
      repeat (FLUSH + 8) @(posedge clk);
      pulseEnable();
      checkOutput("flush_type", 192'(aType), 192'(8'd2));
      checkOutput("flush_present", 192'(aPresent), 192'(4'b0011));
      checkOutput("flush_samples", aSamples, pack2(0, 2));

      // ACR beats audio
      doReset();
      for (int k = 0; k < 4; k++) pushFrame(frame2(k));
      @(negedge clk);
      acr = ~acr;
      pulseEnable();
      checkOutput("acr_type", 192'(aType), 192'(8'd1));
      checkOutput("acr_present", 192'(aPresent), 192'(4'h0));
      pulseEnable();
      checkOutput("acr_then_audio", 192'(aType), 192'(8'd2));
      checkOutput("acr_then_samples", aSamples, pack2(0, 4));

      // Overflow: 17 pushes into 16 entries
      doReset();
      for (int k = 0; k < 17; k++) pushFrame(frame2(k));
      checkOutput("ovf_flag", 192'(aOverflow), 192'(1'b1));
      pulseEnable();
      checkOutput("ovf_first_out", aSamples, pack2(0, 4));
      pulseEnable();
      pulseEnable();
      pulseEnable();
      checkOutput("ovf_last_out", aSamples, pack2(12, 4));
      pulseEnable();
      checkOutput("ovf_drained", 192'(aType), 192'(8'h84));
      checkOutput("ovf_sticky", 192'(aOverflow), 192'(1'b1));

      // Asynchronous reset while an audio packet is held
      for (int k = 0; k < 4; k++) pushFrame(frame2(k));
      pulseEnable();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midrst_type", 192'(aType), 192'(8'h00));
      checkOutput("midrst_samples", aSamples, '0);
      checkOutput("midrst_overflow", 192'(aOverflow), 192'(1'b0));
      @(negedge clk);
      reset = 1'b0;

      // 2-channel frame counter wraps 188 -> 0
      for (int k = 0; k < 48; k++) begin
         for (int j = 0; j < 4; j++) pushFrame(frame2(4*k + j));
         pulseEnable();
         checkOutput("wrap_type", 192'(aType), 192'(8'd2));
         checkOutput("wrap_fc", 192'(aFc), 192'((4*k) % 192));
         endPacket();
      end
      checkOutput("wrap_fc_end", 192'(aFc), 192'(8'd0));

      // 8-channel layout: one frame per packet
      doReset();
      for (int k = 0; k < 48; k++) begin
         pushFrame(frame8(k));
         pulseEnable();
         checkOutput("ml_type", 192'(bType), 192'(8'd2));
         checkOutput("ml_fc", 192'(bFc), 192'(k));
         if (k == 0 || k == 47) begin
            checkOutput("ml_present", 192'(bPresent), 192'(4'hF));
            checkOutput("ml_samples", bSamples, pack8(k));
         end
         endPacket();
      end
      checkOutput("ml_fc_end", 192'(bFc), 192'(8'd48));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
